// File: rtl/avr_cpu_sequencer.sv
// avr_cpu_sequencer: instruction sequencer and program-ROM port arbiter.
// Owns the PC and shares the single ROM read port between fetch and LPM.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   prog_addr/data  ROM word address (comb) / read data (one cycle later)
//   stall           freezes all state for the current cycle
//   opcode, cycle   instruction and execute-cycle index to the execute stage
//   pc_update       signed word delta applied when an instruction retires
//   hold            cycle-0 request for a second execute cycle
//   lpm_read/addr   cycle-0 request for an LPM byte read at byte address Z
//   lpm_data        selected LPM byte, valid in cycle 1
//   pc, retire      PC of instruction in execute; completion pulse
module avr_cpu_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] prog_addr,
  input  logic [15:0] prog_data,
  input  logic        stall,
  output logic [15:0] opcode,
  output logic        cycle,
  input  logic [15:0] pc_update,
  input  logic        hold,
  input  logic        lpm_read,
  input  logic [15:0] lpm_addr,
  output logic [7:0]  lpm_data,
  output logic [15:0] pc,
  output logic        retire
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    CYC1 = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [15:0] opcode_q;
  logic [15:0] opcode_d;
  logic        byte_sel_q;
  logic        byte_sel_d;
  logic [15:0] addr_q;
  logic [15:0] next_pc;

  assign next_pc = pc_q + pc_update;
  assign pc      = pc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      opcode_q   <= 16'h0000;
      byte_sel_q <= 1'b0;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      byte_sel_q <= byte_sel_d;
      // On a stall prog_addr is addr_q, so this simply holds.
      addr_q     <= prog_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    byte_sel_d = byte_sel_q;
    prog_addr  = addr_q;
    opcode     = 16'h0000;
    cycle      = 1'b0;
    retire     = 1'b0;
    lpm_data   = 8'h00;

    unique case (state_q)
      BOOT: begin
        prog_addr = RESET_PC;
        if (!stall) begin
          state_d = RUN;
        end
      end

      RUN: begin
        opcode = prog_data;
        if (!stall) begin
          opcode_d = prog_data;
          if (hold) begin
            state_d = CYC1;
            // LPM takes the port now; the fetch moves to CYC1.
            if (lpm_read) begin
              prog_addr  = {1'b0, lpm_addr[15:1]};
              byte_sel_d = lpm_addr[0];
            end else begin
              prog_addr = pc_q;
            end
          end else begin
            // lpm_read without hold is ignored: fetch keeps the port.
            retire    = 1'b1;
            pc_d      = next_pc;
            prog_addr = next_pc;
          end
        end
      end

      CYC1: begin
        opcode   = opcode_q;
        cycle    = 1'b1;
        lpm_data = byte_sel_q ? prog_data[15:8] : prog_data[7:0];
        if (!stall) begin
          retire    = 1'b1;
          pc_d      = next_pc;
          prog_addr = next_pc;
          state_d   = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_avr_cpu_sequencer.sv
// tb_avr_cpu_sequencer: table-driven bench for avr_cpu_sequencer.
// A behavioural ROM feeds prog_data one cycle after prog_addr.
module tb_avr_cpu_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] prog_addr;
  logic [15:0] prog_data;
  logic        stall;
  logic [15:0] opcode;
  logic        cycle;
  logic [15:0] pc_update;
  logic        hold;
  logic        lpm_read;
  logic [15:0] lpm_addr;
  logic [7:0]  lpm_data;
  logic [15:0] pc;
  logic        retire;

  int n_cmp;
  int n_bad;

  logic [15:0] rom [0:65535];

  avr_cpu_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .stall     (stall),
    .opcode    (opcode),
    .cycle     (cycle),
    .pc_update (pc_update),
    .hold      (hold),
    .lpm_read  (lpm_read),
    .lpm_addr  (lpm_addr),
    .lpm_data  (lpm_data),
    .pc        (pc),
    .retire    (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) prog_data <= rom[prog_addr];

  typedef struct {
    logic        rst;
    logic        stall;
    logic        hold;
    logic        lpm;
    logic [15:0] upd;
    logic [15:0] la;
    logic [15:0] pa;
    logic [15:0] op;
    logic        cyc;
    logic [15:0] pc;
    logic        ret;
    logic [7:0]  ld;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic r, input logic s, input logic h, input logic l,
    input logic [15:0] u, input logic [15:0] a,
    input logic [15:0] epa, input logic [15:0] eop, input logic ec,
    input logic [15:0] epc, input logic er, input logic [7:0] eld);
    vec_t v;
    v.rst = r; v.stall = s; v.hold = h; v.lpm = l;
    v.upd = u; v.la = a;
    v.pa = epa; v.op = eop; v.cyc = ec;
    v.pc = epc; v.ret = er; v.ld = eld;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst       = v.rst;
    stall     = v.stall;
    hold      = v.hold;
    lpm_read  = v.lpm;
    pc_update = v.upd;
    lpm_addr  = v.la;
    #1;
    chk("prog_addr", idx, prog_addr, v.pa);
    chk("opcode", idx, opcode, v.op);
    chk("cycle", idx, {15'd0, cycle}, {15'd0, v.cyc});
    chk("pc", idx, pc, v.pc);
    chk("retire", idx, {15'd0, retire}, {15'd0, v.ret});
    chk("lpm_data", idx, {8'd0, lpm_data}, {8'd0, v.ld});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 65536; i++) rom[i] = 16'hC000 | 16'(i);
    rom[0]     = 16'h1111;
    rom[1]     = 16'h2222;
    rom[2]     = 16'h3333;
    rom[3]     = 16'h4444;
    rom[8]     = 16'hBEEF;
    rom[16'hFFFF] = 16'h5A5A;

    //           rst s h l upd       la        pa        op        c pc        r ld
    // boot + straight line
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0000,16'h0000,0,16'h0000,0,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0001,16'h1111,0,16'h0000,1,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0002,16'h2222,0,16'h0001,1,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0003,16'h3333,0,16'h0002,1,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0004,16'h4444,0,16'h0003,1,8'h00));
    // stall 3 cycles at pc=4
    vq.push_back(mk(1,1,0,0,16'h0001,16'h0000,16'h0004,16'hC004,0,16'h0004,0,8'h00));
    vq.push_back(mk(1,1,0,0,16'h0001,16'h0000,16'h0004,16'hC004,0,16'h0004,0,8'h00));
    vq.push_back(mk(1,1,0,0,16'h0001,16'h0000,16'h0004,16'hC004,0,16'h0004,0,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0005,16'hC004,0,16'h0004,1,8'h00));
    // relative jump -3 at pc=5
    vq.push_back(mk(1,0,0,0,16'hFFFD,16'h0000,16'h0002,16'hC005,0,16'h0005,1,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0003,16'h3333,0,16'h0002,1,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0004,16'h0000,16'h0007,16'h4444,0,16'h0003,1,8'h00));
    // two-cycle at pc=7 (hold ignored in cycle 1)
    vq.push_back(mk(1,0,1,0,16'h0001,16'h0000,16'h0007,16'hC007,0,16'h0007,0,8'h00));
    vq.push_back(mk(1,0,1,0,16'h0001,16'h0000,16'h0008,16'hC007,1,16'h0007,1,8'h07));
    // LPM odd byte at Z=0x0011
    vq.push_back(mk(1,0,1,1,16'h0001,16'h0011,16'h0008,16'hBEEF,0,16'h0008,0,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0011,16'h0009,16'hBEEF,1,16'h0008,1,8'hBE));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h000A,16'hC009,0,16'h0009,1,8'h00));
    // LPM even byte with stall in cycle 1
    vq.push_back(mk(1,0,1,1,16'h0001,16'h0010,16'h0008,16'hC00A,0,16'h000A,0,8'h00));
    vq.push_back(mk(1,1,0,0,16'h0001,16'h0010,16'h0008,16'hC00A,1,16'h000A,0,8'hEF));
    vq.push_back(mk(1,0,0,0,16'h0002,16'h0010,16'h000C,16'hC00A,1,16'h000A,1,8'hEF));
    // lpm_read without hold: ignored
    vq.push_back(mk(1,0,0,1,16'h0001,16'h0011,16'h000D,16'hC00C,0,16'h000C,1,8'h00));
    // reset mid-CYC1
    vq.push_back(mk(1,0,1,0,16'h0001,16'h0000,16'h000D,16'hC00D,0,16'h000D,0,8'h00));
    vq.push_back(mk(0,0,0,0,16'h0001,16'h0000,16'h000E,16'hC00D,1,16'h000D,1,8'h0D));
    // stall in BOOT, then boot
    vq.push_back(mk(1,1,0,0,16'h0001,16'h0000,16'h0000,16'h0000,0,16'h0000,0,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0000,16'h0000,0,16'h0000,0,8'h00));
    // wrap: jump to FFFF then +1
    vq.push_back(mk(1,0,0,0,16'hFFFF,16'h0000,16'hFFFF,16'h1111,0,16'h0000,1,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0000,16'h5A5A,0,16'hFFFF,1,8'h00));
    vq.push_back(mk(1,0,0,0,16'h0001,16'h0000,16'h0001,16'h1111,0,16'h0000,1,8'h00));

    rst       = 1'b0;
    stall     = 1'b0;
    hold      = 1'b0;
    lpm_read  = 1'b0;
    pc_update = 16'h0001;
    lpm_addr  = 16'h0000;
    repeat (2) @(posedge clk);

    foreach (vq[i]) apply(vq[i], i);

    // Hand sequence: reset asserted together with stall mid-LPM.
    apply(mk(1,0,1,1,16'h0001,16'h0011,16'h0008,16'h2222,0,16'h0001,0,8'h00), 100);
    apply(mk(0,1,0,0,16'h0001,16'h0011,16'h0008,16'h2222,1,16'h0001,0,8'hBE), 101);
    apply(mk(1,0,0,0,16'h0001,16'h0000,16'h0000,16'h0000,0,16'h0000,0,8'h00), 102);
    apply(mk(1,0,0,0,16'h0001,16'h0000,16'h0001,16'h1111,0,16'h0000,1,8'h00), 103);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avr_cpu_sequencer.md
# avr_cpu_sequencer

Instruction sequencer and program-memory arbiter for the AVR core. It sits between the synchronous program ROM and `avr_cpu_exec`, and drives `opcode` and `cycle` into the execute stage. It owns the program counter and applies the execute stage's `pc_update` and `hold` outputs. It also shares the single ROM read port between instruction fetch and LPM data reads.

## Interface
Parameters:
- RESET_PC, 16'h0000, word address of the first instruction fetched after reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- prog_addr  out  16  ROM word address; ROM returns data on `prog_data` one cycle later
- prog_data  in  16  ROM read data
- stall  in  1  external wait; freezes the sequencer for the current cycle
- opcode  out  16  instruction to the execute stage
- cycle  out  1  0 = first execute cycle, 1 = second execute cycle
- pc_update  in  16  two's-complement word delta applied when an instruction retires (1 = sequential)
- hold  in  1  from the execute stage; in cycle 0, requests a second cycle of the same opcode
- lpm_read  in  1  in cycle 0, requests the ROM port for an LPM read at `lpm_addr`
- lpm_addr  in  16  LPM byte address (Z); word = lpm_addr[15:1], byte = lpm_addr[0]
- lpm_data  out  8  selected LPM byte, valid in cycle 1
- pc  out  16  word address of the instruction currently in execute
- retire  out  1  one-cycle pulse marking the cycle in which an instruction completes

## Operation
States: BOOT, RUN (cycle 0), CYC1 (cycle 1).

BOOT
- Entered on reset. Outputs: pc=RESET_PC, prog_addr=RESET_PC, opcode=16'h0000, cycle=0, retire=0.
- `pc_update`, `hold` and `lpm_read` are ignored.
- Next state: RUN, unless stall=1.

RUN
- opcode = prog_data, which is also latched into opcode_q. cycle=0.
- If hold=0: retire=1; next_pc = pc + pc_update (mod 2^16); prog_addr = next_pc; pc <= next_pc; stay in RUN.
- If hold=1: retire=0; pc is unchanged; next state CYC1.
  - If lpm_read=1: prog_addr = lpm_addr[15:1], and lpm_addr[0] is latched into byte_sel.
  - Otherwise prog_addr = pc.
- lpm_read with hold=0 is a decoder error. It is ignored, and fetch keeps the port.

CYC1
- opcode = opcode_q; cycle=1.
- lpm_data = byte_sel ? prog_data[15:8] : prog_data[7:0].
- `hold` is ignored, so instructions take at most two cycles.
- retire=1; next_pc = pc + pc_update; prog_addr = next_pc; pc <= next_pc; next state RUN.

Arbitration
- An LPM read always wins the ROM port in the cycle it is requested.
- The fetch of the next instruction moves to CYC1.
- The execute stage never sees a stalled fetch.

Stall
- When stall=1 in any state:
  - state, pc, opcode_q and byte_sel hold;
  - retire=0;
  - prog_addr re-issues the address registered on the previous cycle, so `prog_data` stays valid;
  - opcode, cycle and lpm_data keep presenting the same values.

Other rules
- lpm_data = 8'h00 outside CYC1.
- Reset has priority over stall and over any state. rst=0 at a clock edge puts the sequencer in BOOT with the reset values above, including mid-CYC1 or mid-LPM. A partially executed instruction is abandoned.

## Timing
- Fetch latency: 1 cycle. prog_addr issued in cycle N gives opcode in cycle N+1.
- Throughput: 1 instruction/cycle for single-cycle instructions, with no bubbles on taken jumps, because prog_addr uses combinational next_pc.
- Two-cycle instructions, including LPM: exactly 2 cycles with no bubble.
- After rst rises: 1 BOOT cycle, then the instruction at RESET_PC is in RUN.
- prog_addr and lpm_data are combinational from state, the registered PC and the same-cycle inputs. All other state is registered.
- PC arithmetic is 16-bit with silent wrap: 16'hFFFF + 1 = 16'h0000.

## Test plan
- Reset and straight line:
  - Stimulus: rst=0 for 2 cycles, then release; ROM[0..3] = 16'h1111, 2222, 3333, 4444; pc_update=1.
  - Response: 1 BOOT cycle with opcode=0; then opcode = 1111, 2222, 3333, 4444 on consecutive cycles; pc = 0, 1, 2, 3; retire high every cycle.
- Relative jump:
  - Stimulus: at pc=5, pc_update=16'hFFFD.
  - Response: prog_addr=2 in the same cycle; next cycle pc=2 and opcode=ROM[2]; no bubble.
- Two-cycle instruction:
  - Stimulus: hold=1 at pc=7.
  - Response: opcode held for 2 cycles with cycle = 0 then 1; retire only in the second cycle; pc=8 afterwards.
- LPM odd byte:
  - Stimulus: lpm_read=1 and hold=1 with lpm_addr=16'h0011; ROM[8]=16'hBEEF.
  - Response: prog_addr=8 in cycle 0; lpm_data=8'hBE in cycle 1; the next instruction issues in cycle 1 and executes the following cycle.
- Stall:
  - Stimulus: stall=1 for 3 cycles during RUN at pc=4.
  - Response: opcode, pc and prog_addr stable; retire=0; execution resumes with unchanged state.
- Reset mid-CYC1 and wrap:
  - rst=0 during CYC1 -> BOOT next cycle, pc=RESET_PC.
  - Separately, pc=16'hFFFF with pc_update=1 -> pc=16'h0000.
